// File: rtl/hi_lo_muldiv.sv
// Purpose: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair; also serves MTHI/MTLO.
// Latency: 33 edges from accepted start to done (shift-add / restoring divide, one bit per edge).
// Backpressure: busy high while an op is in flight; start/mthi/mtlo are ignored while busy.
// Optional feature: define MULDIV_EARLY_TERM_EN to let multiplies exit once the multiplier is exhausted.
module hi_lo_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP} state_t;
   state_t state, state_nxt;

   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] mcand;    // multiplicand, shifted left each MUL iteration
   logic [2*WIDTH-1:0] prod;     // product accumulator
   logic [WIDTH-1:0]   mplier;   // multiplier (MUL) or divisor (DIV), both as magnitudes
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quo;      // dividend bits shift out the top while quotient bits shift in
   logic               res_neg;  // product / quotient needs negating
   logic               dvd_neg;  // remainder takes the dividend's sign
   logic               div_op;
   logic               div0;

   logic               signed_op;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [WIDTH:0]     div_shift, div_diff;
   logic               mul_last;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign busy      = (state != S_IDLE);
   assign signed_op = ~op[0];
   assign a_abs     = (signed_op && a[WIDTH-1]) ? -a : a;
   assign b_abs     = (signed_op && b[WIDTH-1]) ? -b : b;

   // Restoring divide step: bring in the next dividend bit, borrow in bit WIDTH means "does not fit".
   assign div_shift = {rem, quo[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, mplier};

`ifdef MULDIV_EARLY_TERM_EN
   // Stop once no multiplier bits remain beyond the one consumed this edge.
   assign mul_last = (mplier[WIDTH-1:1] == '0);
`else
   assign mul_last = (cnt == LAST);
`endif

   // Divide-by-zero keeps the raw all-ones quotient; the remainder sign rule then reproduces a.
   assign prod_fix = res_neg ? -prod : prod;
   assign quo_fix  = (res_neg && !div0) ? -quo : quo;
   assign rem_fix  = dvd_neg ? -rem : rem;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state: IDLE -> MUL|DIV -> FIXUP -> IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = op[1] ? S_DIV : S_MUL;
         S_MUL:   if (mul_last) state_nxt = S_FIXUP;
         S_DIV:   if (cnt == LAST) state_nxt = S_FIXUP;
         S_FIXUP: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath: operand capture, iteration, result write-back and HI/LO moves.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         mcand   <= '0;
         prod    <= '0;
         mplier  <= '0;
         rem     <= '0;
         quo     <= '0;
         res_neg <= 1'b0;
         dvd_neg <= 1'b0;
         div_op  <= 1'b0;
         div0    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         done    <= 1'b0;
      end else begin
         done <= (state == S_FIXUP);
         case (state)
            S_IDLE: begin
               if (start) begin
                  cnt     <= '0;
                  mcand   <= {{WIDTH{1'b0}}, a_abs};
                  prod    <= '0;
                  mplier  <= b_abs;
                  rem     <= '0;
                  quo     <= a_abs;
                  res_neg <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                  dvd_neg <= signed_op & a[WIDTH-1];
                  div_op  <= op[1];
                  div0    <= (b == '0);
               end else begin
                  if (mthi) hi <= wdata;
                  if (mtlo) lo <= wdata;
               end
            end
            S_MUL: begin
               if (mplier[0]) prod <= prod + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CNT_W'(1);
            end
            S_DIV: begin
               if (!div_diff[WIDTH]) begin
                  rem <= div_diff[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= div_shift[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt + CNT_W'(1);
            end
            S_FIXUP: begin
               if (div_op) begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end else begin
                  {hi, lo} <= prod_fix;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hi_lo_muldiv.sv
// Purpose: directed self-checking bench for hi_lo_muldiv.
// Latency: checks 33-edge start-to-done timing (N+1 for early-terminated multiplies).
// Backpressure: checks that start/mthi/mtlo are dropped while busy.
module tb_hi_lo_muldiv;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        mthi, mtlo;
   logic [31:0] wdata;
   logic [31:0] hi, lo;
   logic        busy, done;

   int checks   = 0;
   int failures = 0;

   hi_lo_muldiv #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .mthi  (mthi),
      .mtlo  (mtlo),
      .wdata (wdata),
      .hi    (hi),
      .lo    (lo),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Launch one op (optionally with an mtlo in the same cycle), optionally poke start/mthi
   // mid-flight, and wait (bounded) for done. n = edges from E0 to the edge after which done is seen.
   task automatic run_op(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                         input bit intf, input bit mt_with_start,
                         output int n, output int bcnt,
                         output logic [31:0] mid_hi, output logic [31:0] mid_lo);
      @(negedge clk);
      start = 1'b1; op = o; a = aa; b = bb;
      mtlo  = mt_with_start; wdata = 32'h1111_1111;
      @(negedge clk);
      start = 1'b0; mtlo = 1'b0;
      a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
      n = 0;
      bcnt = busy ? 1 : 0;
      mid_hi = 'x; mid_lo = 'x;
      while (n < 100 && !done) begin
         if (intf && n == 4) begin
            start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
         end else if (intf && n == 9) begin
            mthi = 1'b1; wdata = 32'hDEAD_BEEF;
         end
         @(negedge clk);
         n++;
         start = 1'b0; mthi = 1'b0;
         if (busy) bcnt++;
         if (n == 16) begin
            mid_hi = hi; mid_lo = lo;
         end
      end
   endtask

   initial begin
      int n, bc, dcnt;
      logic [31:0] mh, ml;

      reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      mthi = 1'b0; mtlo = 1'b0; wdata = '0;

      // Reset state
      @(negedge clk);
      chk("reset_hi", hi, 32'h0);
      chk("reset_lo", lo, 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_done", 32'(done), 32'h0);
      reset = 1'b0;

      // 1. MULTU max*max, timing and busy length
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, n, bc, mh, ml);
      chk("multu_max_edges", 32'(n), 32'd33);
      chk("multu_max_busy_cycles", 32'(bc), 32'd33);
      chk("multu_max_hi", hi, 32'hFFFF_FFFE);
      chk("multu_max_lo", lo, 32'h0000_0001);
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'h0);

      // 2. MULT signed
      run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, n, bc, mh, ml);
      chk("mult_neg3x5_hi", hi, 32'hFFFF_FFFF);
      chk("mult_neg3x5_lo", lo, 32'hFFFF_FFF1);
      run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, n, bc, mh, ml);
      chk("mult_min_sq_hi", hi, 32'h4000_0000);
      chk("mult_min_sq_lo", lo, 32'h0);

      // 3. Divides
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, n, bc, mh, ml);
      chk("div_neg7_2_lo", lo, 32'hFFFF_FFFD);
      chk("div_neg7_2_hi", hi, 32'hFFFF_FFFF);
      run_op(2'b11, 32'd7, 32'd2, 1'b0, 1'b0, n, bc, mh, ml);
      chk("divu_7_2_lo", lo, 32'd3);
      chk("divu_7_2_hi", hi, 32'd1);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, n, bc, mh, ml);
      chk("div_min_m1_lo", lo, 32'h8000_0000);
      chk("div_min_m1_hi", hi, 32'h0);

      // 4. Divide by zero
      run_op(2'b11, 32'h1234, 32'h0, 1'b0, 1'b0, n, bc, mh, ml);
      chk("divu_by0_edges", 32'(n), 32'd33);
      chk("divu_by0_lo", lo, 32'hFFFF_FFFF);
      chk("divu_by0_hi", hi, 32'h1234);
      run_op(2'b10, 32'h1234, 32'h0, 1'b0, 1'b0, n, bc, mh, ml);
      chk("div_by0_edges", 32'(n), 32'd33);
      chk("div_by0_lo", lo, 32'hFFFF_FFFF);
      chk("div_by0_hi", hi, 32'h1234);

      // 5. Busy rules: start at E5 and mthi at E10 must be dropped
      run_op(2'b11, 32'd100, 32'd7, 1'b1, 1'b0, n, bc, mh, ml);
      chk("busy_mid_hi_held", mh, 32'h1234);
      chk("busy_mid_lo_held", ml, 32'hFFFF_FFFF);
      chk("busy_edges", 32'(n), 32'd33);
      chk("busy_result_lo", lo, 32'd14);
      chk("busy_result_hi", hi, 32'd2);

      // Idle MTHI
      @(negedge clk);
      mthi = 1'b1; wdata = 32'hA5A5_A5A5;
      @(negedge clk);
      mthi = 1'b0;
      chk("idle_mthi_hi", hi, 32'hA5A5_A5A5);
      chk("idle_mthi_lo_kept", lo, 32'd14);
      chk("idle_mthi_no_done", 32'(done), 32'h0);

      // Start and mtlo together: move dropped
      run_op(2'b11, 32'd9, 32'd4, 1'b0, 1'b1, n, bc, mh, ml);
      chk("start_mtlo_mid_lo", ml, 32'd14);
      chk("start_mtlo_lo", lo, 32'd2);
      chk("start_mtlo_hi", hi, 32'd1);

      // 6. Async reset at E10 of a MULTU
      @(negedge clk);
      start = 1'b1; op = 2'b01; a = 32'd6; b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 32'h0);
      chk("arst_hi", hi, 32'h0);
      chk("arst_lo", lo, 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      chk("arst_no_done", 32'(dcnt), 32'h0);
      run_op(2'b01, 32'd6, 32'd7, 1'b0, 1'b0, n, bc, mh, ml);
      chk("after_rst_lo", lo, 32'd42);
      chk("after_rst_hi", hi, 32'h0);

`ifdef MULDIV_EARLY_TERM_EN
      run_op(2'b01, 32'd5, 32'd1, 1'b0, 1'b0, n, bc, mh, ml);
      chk("early_edges", 32'(n), 32'd2);
      chk("early_lo", lo, 32'd5);
      chk("early_hi", hi, 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
